// File: rtl/fwrisc_trace_pkg.sv
// Shared types for the fwrisc trace arbiter: event kinds, payload layout,
// output-register states and the round-robin helper.
package fwrisc_trace_pkg;

  typedef enum logic {TR_EXEC = 1'b0, TR_RWRITE = 1'b1} trace_kind_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } trace_payload_t;

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_HOLD = 1'b1} out_state_e;

  localparam int unsigned TRACE_DEPTH_DEF  = 4;
  localparam int unsigned TRACE_DROP_W_DEF = 16;

  function automatic trace_kind_e other_kind(input trace_kind_e k);
    return (k == TR_EXEC) ? TR_RWRITE : TR_EXEC;
  endfunction

endpackage

// File: rtl/fwrisc_trace_arbiter_if.sv
// Trace output channel between the arbiter (master) and the trace sink (slave).
interface fwrisc_trace_arbiter_if;
  import fwrisc_trace_pkg::*;

  logic        tr_valid;
  logic        tr_ready;
  trace_kind_e tr_kind;
  logic [31:0] tr_a;
  logic [31:0] tr_b;

  modport master (output tr_valid, tr_kind, tr_a, tr_b, input tr_ready);
  modport slave  (input tr_valid, tr_kind, tr_a, tr_b, output tr_ready);

endinterface

// File: rtl/fwrisc_trace_fifo.sv
// Synchronous per-source event FIFO; an extra pointer bit separates full from
// empty, and a push into a full FIFO is accepted when a pop happens on the same edge.
module fwrisc_trace_fifo
  import fwrisc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  trace_payload_t din,
  output trace_payload_t dout,
  output logic           full,
  output logic           empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  trace_payload_t mem_q [DEPTH];
  trace_payload_t mem_d [DEPTH];
  logic           do_pop;
  logic           accept;

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    accept   = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fwrisc_trace_arbiter.sv
// Captures exec and register-write trace events into per-source FIFOs and drains
// them round-robin through one registered valid/ready channel; overflow is counted.
module fwrisc_trace_arbiter
  import fwrisc_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = TRACE_DEPTH_DEF,
  parameter int unsigned DROP_W = TRACE_DROP_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [31:0]           addr,
  input  logic [31:0]           instr,
  input  logic                  ivalid,
  input  logic [31:0]           raddr,
  input  logic [31:0]           rdata,
  input  logic                  rwrite,
  fwrisc_trace_arbiter_if.master tr,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int unsigned SUM_W = DROP_W + 1;

  trace_payload_t    exec_dout, reg_dout, pay_q, pay_d;
  logic              exec_full, exec_empty, reg_full, reg_empty;
  logic              exec_push, reg_push, exec_pop, reg_pop;
  logic              exec_drop, reg_drop, load, sel_reg;
  out_state_e        state_q, state_d;
  trace_kind_e       kind_q, kind_d, rr_q, rr_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        n_drop;
  logic [SUM_W-1:0]  drop_sum;

  assign exec_push = en && ivalid;
  assign reg_push  = en && rwrite;

  fwrisc_trace_fifo #(.DEPTH(DEPTH)) u_exec_fifo (
    .clock(clock), .reset(reset), .push(exec_push), .pop(exec_pop),
    .din('{a: addr, b: instr}), .dout(exec_dout), .full(exec_full), .empty(exec_empty)
  );

  fwrisc_trace_fifo #(.DEPTH(DEPTH)) u_reg_fifo (
    .clock(clock), .reset(reset), .push(reg_push), .pop(reg_pop),
    .din('{a: raddr, b: rdata}), .dout(reg_dout), .full(reg_full), .empty(reg_empty)
  );

  // Output register FSM plus round-robin choice; the pointer only moves on a real contest.
  always_comb begin
    load     = (state_q == OUT_EMPTY) || tr.tr_ready;
    sel_reg  = !reg_empty && (exec_empty || (rr_q == TR_RWRITE));
    exec_pop = load && !exec_empty && !sel_reg;
    reg_pop  = load && sel_reg;
    rr_d     = rr_q;
    state_d  = state_q;
    kind_d   = kind_q;
    pay_d    = pay_q;
    if (load && !exec_empty && !reg_empty) begin
      rr_d = other_kind(rr_q);
    end
    if (load) begin
      if (reg_pop) begin
        state_d = OUT_HOLD;
        kind_d  = TR_RWRITE;
        pay_d   = reg_dout;
      end else if (exec_pop) begin
        state_d = OUT_HOLD;
        kind_d  = TR_EXEC;
        pay_d   = exec_dout;
      end else begin
        state_d = OUT_EMPTY;
      end
    end
  end

  // A clear on the same edge as a drop restarts the count at this edge's drops.
  always_comb begin
    exec_drop = exec_push && exec_full && !exec_pop;
    reg_drop  = reg_push && reg_full && !reg_pop;
    n_drop    = {1'b0, exec_drop} + {1'b0, reg_drop};
    drop_sum  = {1'b0, drop_q} + SUM_W'(n_drop);
    if (ovf_clr) begin
      drop_d = DROP_W'(n_drop);
      ovf_d  = 1'b0;
    end else begin
      drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      ovf_d  = ovf_q || (n_drop != 2'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OUT_EMPTY;
      kind_q  <= TR_EXEC;
      pay_q   <= '0;
      rr_q    <= TR_EXEC;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pay_q   <= pay_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tr.tr_valid = (state_q == OUT_HOLD);
  assign tr.tr_kind  = kind_q;
  assign tr.tr_a     = pay_q.a;
  assign tr.tr_b     = pay_q.b;
  assign ovf         = ovf_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_fwrisc_trace_arbiter.sv
// Self-checking bench for fwrisc_trace_arbiter: queue-based reference model feeding a
// scoreboard, a negedge monitor, directed scenarios and a randomized phase.
module tb_fwrisc_trace_arbiter;
  import fwrisc_trace_pkg::*;

  localparam int DEPTH    = 4;
  localparam int DROP_W   = 16;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  typedef struct packed {
    logic        kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0, ivalid = 1'b0, rwrite = 1'b0, ovf_clr = 1'b0;
  logic [31:0]       addr = '0, instr = '0, raddr = '0, rdata = '0;
  logic              ovf;
  logic [DROP_W-1:0] drop_count;

  fwrisc_trace_arbiter_if tr_if ();

  fwrisc_trace_arbiter #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset(reset), .en(en), .addr(addr), .instr(instr), .ivalid(ivalid),
    .raddr(raddr), .rdata(rdata), .rwrite(rwrite), .tr(tr_if), .ovf(ovf),
    .ovf_clr(ovf_clr), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int  checks   = 0;
  int  failures = 0;
  bit  mon_en   = 1'b0;

  ev_t m_eq[$], m_rq[$], exp_q[$];
  bit  m_valid = 1'b0;
  bit  m_rr    = 1'b0;
  int  m_drops = 0;
  bit  m_ovf   = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: source queues, one held slot, round-robin flag, drop counter.
  always @(posedge clock) begin : model
    int  nd;
    bit  ne_e, ne_r, take_r;
    ev_t e;
    if (reset) begin
      m_eq.delete(); m_rq.delete(); exp_q.delete();
      m_valid = 1'b0; m_rr = 1'b0; m_drops = 0; m_ovf = 1'b0;
    end else begin
      if (!m_valid || tr_if.tr_ready) begin
        ne_e = (m_eq.size() != 0);
        ne_r = (m_rq.size() != 0);
        if (ne_e || ne_r) begin
          take_r = ne_r && (!ne_e || m_rr);
          if (ne_e && ne_r) m_rr = !m_rr;
          e = take_r ? m_rq.pop_front() : m_eq.pop_front();
          exp_q.push_back(e);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      nd = 0;
      if (en && ivalid) begin
        if (m_eq.size() < DEPTH) m_eq.push_back(ev_t'{kind: 1'b0, a: addr, b: instr});
        else nd++;
      end
      if (en && rwrite) begin
        if (m_rq.size() < DEPTH) m_rq.push_back(ev_t'{kind: 1'b1, a: raddr, b: rdata});
        else nd++;
      end
      if (ovf_clr) begin
        m_drops = nd;
        m_ovf   = 1'b0;
      end else begin
        m_drops = (m_drops + nd > DROP_MAX) ? DROP_MAX : m_drops + nd;
        m_ovf   = m_ovf || (nd != 0);
      end
    end
  end

  // Monitor: compares the presented event with the scoreboard head, pops on handshake.
  always @(negedge clock) begin
    if (mon_en) begin
      check("mon_valid", tr_if.tr_valid, m_valid);
      if (tr_if.tr_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected: got event a=0x%0h expected none", tr_if.tr_a);
        end else begin
          check("mon_event", {tr_if.tr_kind, tr_if.tr_a, tr_if.tr_b}, exp_q[0]);
          if (tr_if.tr_ready) void'(exp_q.pop_front());
        end
      end
      check("mon_drop_count", drop_count, m_drops);
      check("mon_ovf", ovf, m_ovf);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle();
    ivalid = 1'b0; rwrite = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] ins [6];
    logic        prev_kind;
    tr_if.tr_ready = 1'b0;
    step(1);
    mon_en = 1'b1;
    step(1);
    reset = 1'b0;
    check("reset_outputs", {tr_if.tr_valid, tr_if.tr_kind, tr_if.tr_a, tr_if.tr_b, ovf, drop_count}, '0);

    // Single exec event: visible two cycles after it is presented, gone one cycle later.
    en = 1'b1; tr_if.tr_ready = 1'b1;
    ivalid = 1'b1; addr = 32'h8000_0000; instr = 32'h0010_0093;
    step(1);
    idle();
    check("t1_k1_valid", tr_if.tr_valid, 1'b0);
    step(1);
    check("t1_k2_event", {tr_if.tr_valid, tr_if.tr_kind, tr_if.tr_a, tr_if.tr_b},
          {1'b1, 1'b0, 32'h8000_0000, 32'h0010_0093});
    step(1);
    check("t1_k3_valid", tr_if.tr_valid, 1'b0);

    // Simultaneous sources from reset: EXEC first, then RWRITE.
    do_reset();
    ivalid = 1'b1; addr = 32'h8000_0004; instr = 32'h0000_0013;
    rwrite = 1'b1; raddr = 32'd1; rdata = 32'd1;
    step(1);
    idle();
    step(1);
    check("t2_first_kind", tr_if.tr_kind, TR_EXEC);
    step(1);
    check("t2_second", {tr_if.tr_valid, tr_if.tr_kind, tr_if.tr_a, tr_if.tr_b},
          {1'b1, 1'b1, 32'd1, 32'd1});
    step(1);

    // Both FIFOs kept busy: output kinds alternate.
    do_reset();
    prev_kind = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ivalid = 1'b1; addr = $urandom; instr = $urandom;
      rwrite = 1'b1; raddr = $urandom_range(31); rdata = $urandom;
      step(1);
      if (i >= 2) check("t2_alternate", tr_if.tr_kind, !prev_kind);
      prev_kind = tr_if.tr_kind;
    end
    idle();
    step(12);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t5_clear", {ovf, drop_count}, '0);

    // Stalled sink: 6 events -> 1 held, 4 queued, 1 dropped; released in order.
    do_reset();
    tr_if.tr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ins[i] = $urandom;
      ivalid = 1'b1; addr = 32'h0000_1000 + 32'(i * 4); instr = ins[i];
      step(1);
    end
    idle();
    check("t3_drop_count", drop_count, 1);
    check("t3_ovf", ovf, 1'b1);
    check("t3_held", {tr_if.tr_valid, tr_if.tr_a, tr_if.tr_b}, {1'b1, 32'h0000_1000, ins[0]});
    step(3);
    check("t3_stable", {tr_if.tr_valid, tr_if.tr_a, tr_if.tr_b}, {1'b1, 32'h0000_1000, ins[0]});
    tr_if.tr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_order", {tr_if.tr_valid, tr_if.tr_a, tr_if.tr_b},
            {1'b1, 32'h0000_1000 + 32'(i * 4), ins[i]});
      step(1);
    end
    check("t3_drained", tr_if.tr_valid, 1'b0);

    // Full FIFO with a pop on the same edge accepts the push.
    do_reset();
    tr_if.tr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ivalid = 1'b1; addr = 32'h0000_2000 + 32'(i); instr = $urandom;
      step(1);
    end
    check("t4_no_drop_yet", drop_count, 0);
    tr_if.tr_ready = 1'b1; addr = 32'h0000_2005;
    step(1);
    idle();
    check("t4_no_drop", {ovf, drop_count}, '0);
    step(8);

    // Saturation of the drop counter, then a clear that races with two drops.
    do_reset();
    tr_if.tr_ready = 1'b0;
    ivalid = 1'b1; rwrite = 1'b1;
    step(32800);
    check("t5_saturate", {ovf, drop_count}, {1'b1, 16'hFFFF});
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t5_clear_with_drop", {ovf, drop_count}, {1'b0, 16'd2});
    idle();

    // Reset with events queued and one held.
    check("t6_pre_valid", tr_if.tr_valid, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t6_after_reset", {tr_if.tr_valid, tr_if.tr_kind, tr_if.tr_a, tr_if.tr_b, ovf, drop_count}, '0);
    tr_if.tr_ready = 1'b1;
    step(3);
    check("t6_fifos_empty", tr_if.tr_valid, 1'b0);
    en = 1'b0; ivalid = 1'b1; rwrite = 1'b1;
    step(6);
    check("t6_en_off", {tr_if.tr_valid, ovf, drop_count}, '0);
    idle();
    en = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(7) != 0);
      ivalid = $urandom_range(1); addr = $urandom; instr = $urandom;
      rwrite = ($urandom_range(2) == 0); raddr = $urandom_range(31); rdata = $urandom;
      tr_if.tr_ready = ($urandom_range(3) != 0);
      ovf_clr = ($urandom_range(49) == 0);
      step(1);
    end
    idle();
    en = 1'b1;
    tr_if.tr_ready = 1'b1;
    step(12);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
